chol_result_writer: RTL and testbench
=====================================

# chol_result_writer

Write-back sink for the Cholesky stage of the UKF accelerator. Receives diagonal and sub-diagonal results produced under the Cholesky control FSM, computes each element's lower-triangular address, buffers up to four results, and writes them to the L-matrix memory through a valid/ready port. Asserts `stop_pipeline` back to the control FSM when its buffer nears full, closing the loop on the controller's stall input.

## Interface
- `DATA_W`, 32, result word width
- `MAX_N`, 8, maximum matrix dimension; memory row stride
- `ADDR_W`, 6, L-memory address width; `MAX_N*MAX_N` must be at most `2**ADDR_W`
- `clock` in 1: single clock; all logic on posedge
- `areset` in 1: asynchronous, active-high reset
- `matrix_size` in 4: N, legal range 1..`MAX_N`; sampled on accepted `start_begin`
- `start_begin` in 1: start pulse; accepted only in IDLE
- `diag_valid` in 1: one-cycle pulse with `diag_data` = L[j][j]
- `diag_data` in `DATA_W`
- `lower_valid` in 1: one pulse per sub-diagonal result L[i][j], i = j+1..N-1, in order
- `lower_data` in `DATA_W`
- `stop_pipeline` out 1: registered; 1 when FIFO count ≥ 3
- `wr_en` out 1: write valid to L memory
- `wr_addr` out `ADDR_W`: row*`MAX_N`+col
- `wr_data` out `DATA_W`
- `wr_ready` in 1: memory accepts when `wr_en && wr_ready`
- `busy` out 1: high from accepted start until DONE
- `done` out 1: one-cycle pulse on entering DONE
- `err` out 1: sticky; cleared only by reset or accepted start

## Operation
- States: IDLE, DIAG, LOWER, DRAIN, ZERO (macro only), DONE.
- IDLE: `start_begin` latches N, clears col j=0, row i=0, FIFO, `err` → DIAG.
- DIAG: `diag_valid` pushes (j*`MAX_N`+j, `diag_data`); i←j+1. If j=N-1 → DRAIN, else → LOWER.
- LOWER: each `lower_valid` pushes (i*`MAX_N`+j, `lower_data`), i←i+1. After push with i=N-1: j←j+1 → DIAG.
- DRAIN: wait FIFO empty → ZERO (macro) or DONE.
- DONE: pulse `done` one cycle → IDLE.
- FIFO: 4 entries of {addr, data}; push and pop in the same cycle allowed, count unchanged.
- Errors, each setting `err`:
  - push while full: element dropped.
  - `diag_valid` in LOWER, `lower_valid` in DIAG, or both valid in one cycle: ignored, no push, no state change.
  - `matrix_size` of 0 or greater than `MAX_N` at start: immediate → DONE, no writes.
- `start_begin` outside IDLE is ignored.
- N=1: single diag write, no LOWER visit.

## Timing
- Reset values: state IDLE, FIFO empty, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `stop_pipeline`=0, `busy`=0, `done`=0, `err`=0.
- Element pushed on the valid cycle; `wr_en` high no earlier than the next cycle (registered FIFO head). Minimum latency valid→write is 1 cycle.
- `wr_addr`/`wr_data` must hold stable while `wr_en && !wr_ready`.
- `stop_pipeline` updates one cycle after the count change; the upstream stall has ≥1 cycle slack, so threshold 3 of 4 prevents overflow under a legal response.
- `areset` mid-operation: FIFO contents discarded, in-flight writes abandoned, all outputs return to reset values asynchronously.
- `busy` falls in the cycle `done` pulses.

## Configuration
- `CHOL_WR_ZERO_UPPER_EN` defined:
  - DRAIN → ZERO, which writes 0 to every (i,j) with j>i, i<N, row-major, one per handshake.
  - `stop_pipeline` is held 1 throughout ZERO.
  - Then → DONE.
- Undefined: ZERO state absent; DRAIN → DONE; upper triangle untouched.

## Test plan
- N=3, `wr_ready`=1, valid order D,L,L,D,L,D with data 1..6 → writes (addr:data) 0:1, 8:2, 16:3, 9:4, 17:5, 18:6; `done` pulses once; `err`=0.
- N=4, `wr_ready`=0 for 10 cycles with four back-to-back valids → `stop_pipeline`=1 one cycle after count reaches 3; no data lost; all writes emerge in order once ready.
- Five valids while `wr_ready`=0 → fifth dropped, `err`=1, first four written in order.
- `diag_valid` and `lower_valid` together in LOWER → no push, `err`=1, state unchanged.
- `areset` asserted mid-LOWER with 2 FIFO entries → `wr_en`=0 immediately; new start N=1 writes addr 0 only.
- With `CHOL_WR_ZERO_UPPER_EN`, N=3 → after six result writes, zeros to addrs 1, 2, 10, then `done`.

Source files
------------

// File: rtl/chol_result_writer.sv
// rtl/chol_result_writer.sv - Cholesky L-matrix write-back sink with a 4-entry result FIFO
// Optional CHOL_WR_ZERO_UPPER_EN: zero-fill the upper triangle once all results are written.
module chol_result_writer #(
  parameter int DATA_W = 32,
  parameter int MAX_N  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              areset,
  input  logic [3:0]        matrix_size,
  input  logic              start_begin,
  input  logic              diag_valid,
  input  logic [DATA_W-1:0] diag_data,
  input  logic              lower_valid,
  input  logic [DATA_W-1:0] lower_data,
  output logic              stop_pipeline,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {
    IDLE,
    DIAG,
    LOWER,
    DRAIN,
`ifdef CHOL_WR_ZERO_UPPER_EN
    ZERO,
`endif
    DONE
  } state_t;

  state_t            state;
  logic [3:0]        n;
  logic [3:0]        col;
  logic [3:0]        row;
  logic [ADDR_W-1:0] fifo_addr [4];
  logic [DATA_W-1:0] fifo_data [4];
  logic [1:0]        wptr;
  logic [1:0]        rptr;
  logic [2:0]        count;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              bad_valid;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_data;
`ifdef CHOL_WR_ZERO_UPPER_EN
  logic [3:0]        zrow;
  logic [3:0]        zcol;
  logic              zfill_done;
`endif

  // The FIFO head is driven straight from storage, so it holds while the memory stalls.
  assign wr_en   = (count != 3'd0);
  assign wr_addr = fifo_addr[rptr];
  assign wr_data = fifo_data[rptr];
  assign pop     = wr_en && wr_ready;
  assign push_ok = push_req && (count != 3'd4);

  always_comb begin
    push_req  = 1'b0;
    push_addr = '0;
    push_data = '0;
    bad_valid = 1'b0;
    case (state)
      DIAG: begin
        bad_valid = lower_valid;
        push_req  = diag_valid && !lower_valid;
        push_addr = ADDR_W'(int'(col) * MAX_N + int'(col));
        push_data = diag_data;
      end
      LOWER: begin
        bad_valid = diag_valid;
        push_req  = lower_valid && !diag_valid;
        push_addr = ADDR_W'(int'(row) * MAX_N + int'(col));
        push_data = lower_data;
      end
`ifdef CHOL_WR_ZERO_UPPER_EN
      ZERO: begin
        push_req  = !zfill_done && (count != 3'd4);
        push_addr = ADDR_W'(int'(zrow) * MAX_N + int'(zcol));
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      n             <= '0;
      col           <= '0;
      row           <= '0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      stop_pipeline <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        fifo_addr[k] <= '0;
        fifo_data[k] <= '0;
      end
`ifdef CHOL_WR_ZERO_UPPER_EN
      zrow          <= '0;
      zcol          <= '0;
      zfill_done    <= 1'b0;
`endif
    end else begin
      done          <= 1'b0;
      stop_pipeline <= (count >= 3'd3);
      if (push_ok) begin
        fifo_addr[wptr] <= push_addr;
        fifo_data[wptr] <= push_data;
        wptr            <= wptr + 2'd1;
      end
      if (pop) rptr <= rptr + 2'd1;
      count <= count + {2'b0, push_ok} - {2'b0, pop};
      if ((push_req && !push_ok) || bad_valid) err <= 1'b1;

      case (state)
        IDLE: if (start_begin) begin
          n     <= matrix_size;
          col   <= '0;
          row   <= '0;
          wptr  <= '0;
          rptr  <= '0;
          count <= '0;
          err   <= 1'b0;
          if (matrix_size == 4'd0 || int'(matrix_size) > MAX_N) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            busy  <= 1'b1;
            state <= DIAG;
          end
        end
        DIAG: if (push_req) begin
          if (col == n - 4'd1) state <= DRAIN;
          else begin
            row   <= col + 4'd1;
            state <= LOWER;
          end
        end
        LOWER: if (push_req) begin
          if (row == n - 4'd1) begin
            col   <= col + 4'd1;
            state <= DIAG;
          end else row <= row + 4'd1;
        end
        DRAIN: if (count == 3'd0) begin
`ifdef CHOL_WR_ZERO_UPPER_EN
          zrow          <= '0;
          zcol          <= 4'd1;
          zfill_done    <= (n == 4'd1);
          stop_pipeline <= 1'b1;
          state         <= ZERO;
`else
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
`endif
        end
`ifdef CHOL_WR_ZERO_UPPER_EN
        ZERO: begin
          stop_pipeline <= 1'b1;
          if (push_ok) begin
            // Row n-2 holds the last upper-triangle element.
            if (zcol == n - 4'd1) begin
              if (zrow == n - 4'd2) zfill_done <= 1'b1;
              else begin
                zrow <= zrow + 4'd1;
                zcol <= zrow + 4'd2;
              end
            end else zcol <= zcol + 4'd1;
          end else if (zfill_done && count == 3'd0) begin
            stop_pipeline <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b1;
            state         <= DONE;
          end
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chol_result_writer.sv
// tb/tb_chol_result_writer.sv - self-checking bench for chol_result_writer
// Reference: element order and L-memory addresses derived from the triangular traversal.
module tb_chol_result_writer;
  localparam int DATA_W = 32;
  localparam int MAX_N  = 8;
  localparam int ADDR_W = 6;
`ifdef CHOL_WR_ZERO_UPPER_EN
  localparam bit ZERO_EN = 1'b1;
`else
  localparam bit ZERO_EN = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              areset = 1'b1;
  logic [3:0]        matrix_size = '0;
  logic              start_begin = 1'b0;
  logic              diag_valid = 1'b0;
  logic [DATA_W-1:0] diag_data = '0;
  logic              lower_valid = 1'b0;
  logic [DATA_W-1:0] lower_data = '0;
  logic              stop_pipeline;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready = 1'b0;
  logic              busy;
  logic              done;
  logic              err;

  always #5 clock = ~clock;

  chol_result_writer #(.DATA_W(DATA_W), .MAX_N(MAX_N), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .areset(areset), .matrix_size(matrix_size), .start_begin(start_begin),
    .diag_valid(diag_valid), .diag_data(diag_data), .lower_valid(lower_valid),
    .lower_data(lower_data), .stop_pipeline(stop_pipeline), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready), .busy(busy),
    .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int done_base = 0;
  int ready_mode = 0;
  int got_addr[$];
  int got_data[$];
  int exp_addr[$];
  int exp_data[$];
  int ord_addr[$];
  bit ord_diag[$];

  // Writes are captured mid-cycle; the handshake completes on the following posedge.
  always @(negedge clock) begin
    if (!areset && wr_en && wr_ready) begin
      got_addr.push_back(int'(wr_addr));
      got_data.push_back(int'(wr_data));
    end
    if (done) done_cnt++;
  end

  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: wr_ready = 1'b0;
      1: wr_ready = 1'b1;
      default: wr_ready = 1'($urandom_range(0, 1));
    endcase
  end

  initial begin
    #3000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic void build_order(input int n);
    ord_addr.delete();
    ord_diag.delete();
    for (int j = 0; j < n; j++) begin
      ord_addr.push_back(j * MAX_N + j);
      ord_diag.push_back(1'b1);
      for (int i = j + 1; i < n; i++) begin
        ord_addr.push_back(i * MAX_N + j);
        ord_diag.push_back(1'b0);
      end
    end
  endfunction

  function automatic void add_zero_upper(input int n);
    for (int i = 0; i < n; i++)
      for (int j = i + 1; j < n; j++)
        if (ZERO_EN) begin
          exp_addr.push_back(i * MAX_N + j);
          exp_data.push_back(0);
        end
  endfunction

  function automatic void clear_all();
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
    exp_data.delete();
    done_base = done_cnt;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start(input int n);
    matrix_size = 4'(n);
    start_begin = 1'b1;
    tick();
    start_begin = 1'b0;
  endtask

  task automatic send(input bit is_diag, input bit both, input bit honor, input int d);
    int g = 0;
    while (honor && stop_pipeline && g < 200) begin
      tick();
      g++;
    end
    if (is_diag || both) begin diag_valid = 1'b1; diag_data = d; end
    if (!is_diag || both) begin lower_valid = 1'b1; lower_data = d; end
    tick();
    diag_valid = 1'b0;
    lower_valid = 1'b0;
  endtask

  task automatic wait_done();
    int g = 0;
    while (done_cnt == done_base && g < 3000) begin
      tick();
      g++;
    end
    tick();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    areset = 1'b0;
    #1;
    n_cmp += 7;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got=%b expected=0", wr_en); end
    if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr got=%0d expected=0", wr_addr); end
    if (wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data got=%0d expected=0", wr_data); end
    if (stop_pipeline !== 1'b0) begin n_fail++; $display("FAIL reset_stop got=%b expected=0", stop_pipeline); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b expected=0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b expected=0", done); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b expected=0", err); end
    tick();
  endtask

  task automatic test_basic_n3();
    clear_all();
    ready_mode = 1;
    tick();
    start(3);
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL n3_busy got=%b expected=1", busy); end
    build_order(3);
    for (int k = 0; k < 6; k++) begin
      exp_addr.push_back(ord_addr[k]);
      exp_data.push_back(k + 1);
      send(ord_diag[k], 1'b0, 1'b1, k + 1);
      if (k == 0) start(5);
    end
    add_zero_upper(3);
    wait_done();
    n_cmp += 4;
    if (done_cnt - done_base !== 1) begin n_fail++; $display("FAIL n3_done_pulses got=%0d expected=1", done_cnt - done_base); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL n3_err got=%b expected=0", err); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL n3_busy_end got=%b expected=0", busy); end
    if (got_addr.size() !== exp_addr.size()) begin n_fail++; $display("FAIL n3_write_count got=%0d expected=%0d", got_addr.size(), exp_addr.size()); end
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      n_cmp++;
      if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
        n_fail++;
        $display("FAIL n3_write[%0d] got=%0d:%0d expected=%0d:%0d", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_random_matrices();
    for (int r = 0; r < 6; r++) begin
      int n;
      clear_all();
      n = $urandom_range(1, MAX_N);
      ready_mode = 2;
      start(n);
      build_order(n);
      for (int k = 0; k < ord_addr.size(); k++) begin
        int d = int'($urandom);
        repeat ($urandom_range(0, 2)) tick();
        exp_addr.push_back(ord_addr[k]);
        exp_data.push_back(d);
        send(ord_diag[k], 1'b0, 1'b1, d);
      end
      add_zero_upper(n);
      wait_done();
      n_cmp += 3;
      if (done_cnt - done_base !== 1) begin n_fail++; $display("FAIL rand_done n=%0d got=%0d expected=1", n, done_cnt - done_base); end
      if (err !== 1'b0) begin n_fail++; $display("FAIL rand_err n=%0d got=%b expected=0", n, err); end
      if (got_addr.size() !== exp_addr.size()) begin n_fail++; $display("FAIL rand_write_count n=%0d got=%0d expected=%0d", n, got_addr.size(), exp_addr.size()); end
      for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
        n_cmp++;
        if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
          n_fail++;
          $display("FAIL rand_write[%0d] n=%0d got=%0d:%0d expected=%0d:%0d", k, n, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_all();
    ready_mode = 0;
    tick();
    tick();
    start(4);
    build_order(4);
    for (int k = 0; k < ord_addr.size(); k++) begin
      int d = int'($urandom);
      exp_addr.push_back(ord_addr[k]);
      exp_data.push_back(d);
      if (k < 4) send(ord_diag[k], 1'b0, 1'b0, d);
      else send(ord_diag[k], 1'b0, 1'b1, d);
      if (k == 0) begin
        n_cmp++;
        if (wr_en !== 1'b1) begin n_fail++; $display("FAIL bp_first_latency wr_en got=%b expected=1", wr_en); end
      end
      if (k == 2) begin
        n_cmp++;
        if (stop_pipeline !== 1'b0) begin n_fail++; $display("FAIL bp_stop_early got=%b expected=0", stop_pipeline); end
      end
      if (k == 3) begin
        n_cmp++;
        if (stop_pipeline !== 1'b1) begin n_fail++; $display("FAIL bp_stop_at_3 got=%b expected=1", stop_pipeline); end
        repeat (6) tick();
        n_cmp += 3;
        if (got_addr.size() !== 0) begin n_fail++; $display("FAIL bp_no_write_stalled got=%0d expected=0", got_addr.size()); end
        if (int'(wr_addr) !== exp_addr[0]) begin n_fail++; $display("FAIL bp_head_addr got=%0d expected=%0d", wr_addr, exp_addr[0]); end
        if (int'(wr_data) !== exp_data[0]) begin n_fail++; $display("FAIL bp_head_data got=%0d expected=%0d", wr_data, exp_data[0]); end
        ready_mode = 1;
      end
    end
    add_zero_upper(4);
    wait_done();
    n_cmp += 3;
    if (done_cnt - done_base !== 1) begin n_fail++; $display("FAIL bp_done got=%0d expected=1", done_cnt - done_base); end
    if (err !== 1'b0) begin n_fail++; $display("FAIL bp_err got=%b expected=0", err); end
    if (got_addr.size() !== exp_addr.size()) begin n_fail++; $display("FAIL bp_write_count got=%0d expected=%0d", got_addr.size(), exp_addr.size()); end
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      n_cmp++;
      if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
        n_fail++;
        $display("FAIL bp_write[%0d] got=%0d:%0d expected=%0d:%0d", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_overflow();
    clear_all();
    ready_mode = 0;
    tick();
    tick();
    start(8);
    build_order(8);
    for (int k = 0; k < ord_addr.size(); k++) begin
      int d = int'($urandom);
      if (k != 4) begin
        exp_addr.push_back(ord_addr[k]);
        exp_data.push_back(d);
      end
      send(ord_diag[k], 1'b0, (k > 4), d);
      if (k == 4) begin
        n_cmp++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got=%b expected=1", err); end
        ready_mode = 1;
      end
    end
    add_zero_upper(8);
    wait_done();
    n_cmp += 3;
    if (done_cnt - done_base !== 1) begin n_fail++; $display("FAIL ovf_done got=%0d expected=1", done_cnt - done_base); end
    if (err !== 1'b1) begin n_fail++; $display("FAIL ovf_err_sticky got=%b expected=1", err); end
    if (got_addr.size() !== exp_addr.size()) begin n_fail++; $display("FAIL ovf_write_count got=%0d expected=%0d", got_addr.size(), exp_addr.size()); end
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      n_cmp++;
      if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
        n_fail++;
        $display("FAIL ovf_write[%0d] got=%0d:%0d expected=%0d:%0d", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
  endtask

  task automatic test_illegal_valids();
    clear_all();
    ready_mode = 1;
    start(3);
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_cleared_by_start got=%b expected=0", err); end
    build_order(3);
    for (int k = 0; k < 6; k++) begin
      int d = int'($urandom);
      exp_addr.push_back(ord_addr[k]);
      exp_data.push_back(d);
      send(ord_diag[k], 1'b0, 1'b1, d);
      if (k == 0) begin
        send(1'b0, 1'b1, 1'b1, 32'h0bad_0bad);
        n_cmp++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL both_valid_err got=%b expected=1", err); end
      end
    end
    add_zero_upper(3);
    wait_done();
    n_cmp += 2;
    if (done_cnt - done_base !== 1) begin n_fail++; $display("FAIL both_valid_done got=%0d expected=1", done_cnt - done_base); end
    if (got_addr.size() !== exp_addr.size()) begin n_fail++; $display("FAIL both_valid_write_count got=%0d expected=%0d", got_addr.size(), exp_addr.size()); end
    for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
      n_cmp++;
      if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
        n_fail++;
        $display("FAIL both_valid_write[%0d] got=%0d:%0d expected=%0d:%0d", k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
    clear_all();
    start(2);
    send(1'b0, 1'b0, 1'b1, 77);
    n_cmp++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL lower_in_diag_err got=%b expected=1", err); end
    build_order(2);
    for (int k = 0; k < 3; k++) send(ord_diag[k], 1'b0, 1'b1, k);
    wait_done();
    n_cmp += 2;
    if (done_cnt - done_base !== 1) begin n_fail++; $display("FAIL lower_in_diag_done got=%0d expected=1", done_cnt - done_base); end
    if (got_addr.size() !== 3 + (ZERO_EN ? 1 : 0)) begin n_fail++; $display("FAIL lower_in_diag_write_count got=%0d expected=%0d", got_addr.size(), 3 + (ZERO_EN ? 1 : 0)); end
  endtask

  task automatic test_bad_size();
    int sizes[3] = '{0, 9, 15};
    for (int s = 0; s < 3; s++) begin
      clear_all();
      ready_mode = 1;
      start(sizes[s]);
      wait_done();
      n_cmp += 4;
      if (done_cnt - done_base !== 1) begin n_fail++; $display("FAIL bad_size_done n=%0d got=%0d expected=1", sizes[s], done_cnt - done_base); end
      if (err !== 1'b1) begin n_fail++; $display("FAIL bad_size_err n=%0d got=%b expected=1", sizes[s], err); end
      if (busy !== 1'b0) begin n_fail++; $display("FAIL bad_size_busy n=%0d got=%b expected=0", sizes[s], busy); end
      if (got_addr.size() !== 0) begin n_fail++; $display("FAIL bad_size_writes n=%0d got=%0d expected=0", sizes[s], got_addr.size()); end
    end
  endtask

  task automatic test_reset_mid();
    int d;
    clear_all();
    ready_mode = 0;
    tick();
    tick();
    start(4);
    send(1'b1, 1'b0, 1'b0, 11);
    send(1'b0, 1'b0, 1'b0, 22);
    #2;
    areset = 1'b1;
    #1;
    n_cmp += 4;
    if (wr_en !== 1'b0) begin n_fail++; $display("FAIL midreset_wr_en got=%b expected=0", wr_en); end
    if (wr_addr !== '0) begin n_fail++; $display("FAIL midreset_wr_addr got=%0d expected=0", wr_addr); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got=%b expected=0", busy); end
    if (wr_data !== '0) begin n_fail++; $display("FAIL midreset_wr_data got=%0d expected=0", wr_data); end
    tick();
    areset = 1'b0;
    clear_all();
    ready_mode = 1;
    tick();
    start(1);
    d = int'($urandom);
    exp_addr.push_back(0);
    exp_data.push_back(d);
    send(1'b1, 1'b0, 1'b1, d);
    wait_done();
    n_cmp += 2;
    if (done_cnt - done_base !== 1) begin n_fail++; $display("FAIL n1_done got=%0d expected=1", done_cnt - done_base); end
    if (got_addr.size() !== 1) begin n_fail++; $display("FAIL n1_write_count got=%0d expected=1", got_addr.size()); end
    for (int k = 0; k < 1 && k < got_addr.size(); k++) begin
      n_cmp++;
      if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
        n_fail++;
        $display("FAIL n1_write got=%0d:%0d expected=%0d:%0d", got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_n3();
    test_random_matrices();
    test_backpressure();
    test_overflow();
    test_illegal_valids();
    test_bad_size();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
